data_mem_lsu: RTL and testbench

Load/store stage directly downstream of the RV32I DataPath.
- Consumes aluRes (address), writeData and f3 from the DataPath.
- Produces readData back into the DataPath result mux.
- Contains a word-organised synchronous RAM with byte lanes, plus store byte-lane steering, load extraction and sign/zero extension.
- Loads take two cycles because the RAM read is synchronous; a stall output holds the PC and instruction for that extra cycle.

---
 rtl/rv32_mem_pkg.sv | 32 +++
 rtl/data_mem_lsu_byte_ram.sv | 33 +++
 rtl/data_mem_lsu.sv | 145 ++++++++++++++
 tb/tb_data_mem_lsu.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the RV32I load/store path.
//   - funct3 encodings for the byte/half/word access sizes
//   - LSU state encoding (IDLE/RESP)
//   - accessLegal(): size/alignment legality of a load or store
package rv32_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [0:0] LSU_IDLE = 1'b0;
  localparam logic [0:0] LSU_RESP = 1'b1;

  // Unsigned variants only exist for loads; stores use B/H/W.
  function automatic logic accessLegal(input logic [2:0] f3,
                                       input logic [1:0] off,
                                       input logic       isStore);
    logic ok;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~off[0];
      F3_W:    ok = (off == 2'b00);
      F3_BU:   ok = ~isStore;
      F3_HU:   ok = ~isStore & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/data_mem_lsu_byte_ram.sv
// Word-organised synchronous RAM with per-byte write enables.
// Ports:
//   clk    - clock, write and read both on the rising edge
//   we     - byte-lane write enables (bit i writes wData[8i+7:8i])
//   addr   - word index shared by write and read
//   wData  - write data (already steered onto lanes)
//   rdEn   - registers mem[addr] into rData at the edge
//   rData  - registered read data
// Read-first: a read and write to the same word in one edge returns the
// old contents. Contents are never cleared.
module byte_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wData,
  input  logic              rdEn,
  output logic [31:0]       rData
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][i*8 +: 8] <= wData[i*8 +: 8];
    end
    if (rdEn) rData <= mem[addr];
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store unit sitting after the RV32I DataPath.
// Ports:
//   clk, rst   - clock; synchronous active-high reset
//   memRead    - load request
//   memWrite   - store request
//   f3         - funct3: access size and sign
//   addr       - byte address (aluRes); wraps modulo RAM size
//   writeData  - store data, low bits used for SB/SH
//   readData   - formatted load data, valid only in RESP, else 0
//   stall      - load waiting for RAM data; core freezes PC/instruction
//   fault      - misaligned access, illegal f3 or read+write collision
//   dbgState   - current LSU state (0=IDLE, 1=RESP)
//
// Request/response protocol: in IDLE a legal memRead (without memWrite) is
// accepted in the same cycle it is seen and stall is raised combinationally
// for that cycle; the following cycle is RESP, where stall is low, readData
// carries the result and memRead is ignored. Stores complete at the edge of
// the cycle they are presented and never stall.
module data_mem_lsu
  import rv32_mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  f3,
  input  logic [31:0] addr,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        stall,
  output logic        fault,
  output logic        dbgState
);

  logic [0:0]        state;
  logic [0:0]        stateNext;
  logic [1:0]        off;
  logic [ADDR_W-1:0] wordIdx;
  logic              inIdle;
  logic              legal;
  logic              doWrite;
  logic              loadStart;
  logic [3:0]        byteEn;
  logic [3:0]        ramWe;
  logic [31:0]       laneData;
  logic [31:0]       ramData;
  logic [1:0]        offQ;
  logic [2:0]        f3Q;
  logic [7:0]        byteSel;
  logic [15:0]       halfSel;
  logic              unusedAddrBits;

  assign off            = addr[1:0];
  assign wordIdx        = addr[ADDR_W+1:2];
  assign unusedAddrBits = ^addr[31:ADDR_W+2];
  assign dbgState       = state[0];

  // A collision is handled as a store, so legality uses store rules whenever
  // memWrite is set. Nothing is accepted or flagged outside IDLE.
  always_comb begin
    inIdle    = (state == LSU_IDLE);
    legal     = accessLegal(f3, off, memWrite);
    fault     = ~rst & inIdle & (memRead | memWrite) & (~legal | (memRead & memWrite));
    doWrite   = ~rst & inIdle & memWrite & legal;
    loadStart = ~rst & inIdle & memRead & ~memWrite & legal;
    stall     = loadStart;
    stateNext = loadStart ? LSU_RESP : LSU_IDLE;
  end

  // Store lane steering: data is replicated so the enabled lane(s) always
  // see the right bytes regardless of offset.
  always_comb begin
    byteEn   = 4'b0000;
    laneData = writeData;
    case (f3)
      F3_B: begin
        byteEn   = 4'b0001 << off;
        laneData = {4{writeData[7:0]}};
      end
      F3_H: begin
        byteEn   = off[1] ? 4'b1100 : 4'b0011;
        laneData = {2{writeData[15:0]}};
      end
      F3_W: begin
        byteEn   = 4'b1111;
        laneData = writeData;
      end
      default: begin
        byteEn   = 4'b0000;
        laneData = writeData;
      end
    endcase
    ramWe = doWrite ? byteEn : 4'b0000;
  end

  byte_ram #(
    .ADDR_W(ADDR_W)
  ) uRam (
    .clk  (clk),
    .we   (ramWe),
    .addr (wordIdx),
    .wData(laneData),
    .rdEn (loadStart),
    .rData(ramData)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LSU_IDLE;
      offQ  <= 2'b00;
      f3Q   <= F3_B;
    end else begin
      state <= stateNext;
      if (loadStart) begin
        offQ <= off;
        f3Q  <= f3;
      end
    end
  end

  // Load formatting from the registered RAM word and the captured offset/f3.
  always_comb begin
    case (offQ)
      2'd0:    byteSel = ramData[7:0];
      2'd1:    byteSel = ramData[15:8];
      2'd2:    byteSel = ramData[23:16];
      default: byteSel = ramData[31:24];
    endcase
    halfSel  = offQ[1] ? ramData[31:16] : ramData[15:0];
    readData = 32'h0;
    if (state == LSU_RESP) begin
      case (f3Q)
        F3_B:    readData = {{24{byteSel[7]}}, byteSel};
        F3_BU:   readData = {24'h0, byteSel};
        F3_H:    readData = {{16{halfSel[15]}}, halfSel};
        F3_HU:   readData = {16'h0, halfSel};
        F3_W:    readData = ramData;
        default: readData = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Self-checking bench for data_mem_lsu: directed steps followed by a random
// mix of loads, stores and collisions, compared against a byte-addressed
// reference memory.
module tb_data_mem_lsu;

  localparam int ADDR_W   = 10;
  localparam int MEM_BYTES = 4 << ADDR_W;

  logic        clk;
  logic        rst;
  logic        memRead;
  logic        memWrite;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        stall;
  logic        fault;
  logic        dbgState;

  int checks;
  int failures;

  logic [7:0] bmem [MEM_BYTES];

  data_mem_lsu #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .memRead  (memRead),
    .memWrite (memWrite),
    .f3       (f3),
    .addr     (addr),
    .writeData(writeData),
    .readData (readData),
    .stall    (stall),
    .fault    (fault),
    .dbgState (dbgState)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference model: access size in bytes, 0 if funct3 is not usable
  function automatic int accSize(input logic [2:0] f, input logic isStore);
    int s;
    case (f)
      3'd0: s = 1;
      3'd1: s = 2;
      3'd2: s = 4;
      3'd4: s = isStore ? 0 : 1;
      3'd5: s = isStore ? 0 : 2;
      default: s = 0;
    endcase
    return s;
  endfunction

  function automatic logic modelLegal(input logic [2:0] f, input logic [31:0] a, input logic isStore);
    int s;
    s = accSize(f, isStore);
    return (s != 0) && ((a % s) == 0);
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] f, input logic [31:0] a);
    int s;
    logic [31:0] v;
    s = accSize(f, 1'b0);
    v = 0;
    for (int i = 0; i < s; i++) v = v | (32'(bmem[(a + i) % MEM_BYTES]) << (8 * i));
    if (f == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
    if (f == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic modelStore(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    int s;
    s = accSize(f, 1'b1);
    for (int i = 0; i < s; i++) bmem[(a + i) % MEM_BYTES] = 8'(d >> (8 * i));
  endtask

  // driver: one access, including the RESP cycle for accepted loads
  task automatic access(input logic rd, input logic wr, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] d, input string tag);
    logic isLegal;
    logic expFault;
    logic expStall;
    logic [31:0] expData;
    isLegal  = modelLegal(f, a, wr);
    expFault = (rd | wr) & (~isLegal | (rd & wr));
    expStall = rd & ~wr & isLegal;
    expData  = expStall ? modelLoad(f, a) : 32'h0;
    @(negedge clk);
    memRead = rd; memWrite = wr; f3 = f; addr = a; writeData = d;
    #1;
    check({tag, ".stall"}, 32'(stall), 32'(expStall));
    check({tag, ".fault"}, 32'(fault), 32'(expFault));
    check({tag, ".idleData"}, readData, 32'h0);
    check({tag, ".idleState"}, 32'(dbgState), 32'h0);
    @(posedge clk);
    if (wr && isLegal) modelStore(f, a, d);
    if (expStall) begin
      @(negedge clk);
      memRead = 1'b0; memWrite = 1'b0;
      #1;
      check({tag, ".respStall"}, 32'(stall), 32'h0);
      check({tag, ".respFault"}, 32'(fault), 32'h0);
      check({tag, ".respState"}, 32'(dbgState), 32'h1);
      check({tag, ".respData"}, readData, expData);
      @(posedge clk);
    end
  endtask

  task automatic idleCycle();
    @(negedge clk);
    memRead = 1'b0; memWrite = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; memRead = 1'b0; memWrite = 1'b0; f3 = 3'd0; addr = 0; writeData = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.data", readData, 32'h0);
    check("reset.stall", 32'(stall), 32'h0);
    check("reset.fault", 32'(fault), 32'h0);
    check("reset.state", 32'(dbgState), 32'h0);
    rst = 1'b0;

    // give the first 256 bytes defined contents
    for (int i = 0; i < 64; i++) access(1'b0, 1'b1, 3'd2, 32'(i * 4), $urandom, "init");

    // 1: word store/load
    access(1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, "t1.sw");
    access(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, "t1.lw");
    check("t1.model", modelLoad(3'd2, 32'h10), 32'hDEADBEEF);

    // 2: byte store, signed/unsigned byte loads, neighbouring bytes untouched
    access(1'b0, 1'b1, 3'd0, 32'h21, 32'h0000_0080, "t2.sb");
    access(1'b1, 1'b0, 3'd0, 32'h21, 32'h0, "t2.lb");
    access(1'b1, 1'b0, 3'd4, 32'h21, 32'h0, "t2.lbu");
    access(1'b1, 1'b0, 3'd2, 32'h20, 32'h0, "t2.lw");

    // 3: half store, signed/unsigned half loads, lower half untouched
    access(1'b0, 1'b1, 3'd1, 32'h32, 32'hABCD_8001, "t3.sh");
    access(1'b1, 1'b0, 3'd1, 32'h32, 32'h0, "t3.lh");
    access(1'b1, 1'b0, 3'd5, 32'h32, 32'h0, "t3.lhu");
    access(1'b1, 1'b0, 3'd1, 32'h30, 32'h0, "t3.lhlow");

    // 4: misaligned load and store fault, no write
    access(1'b0, 1'b1, 3'd2, 32'h40, 32'hA5A5_5A5A, "t4.sw");
    access(1'b1, 1'b0, 3'd2, 32'h13, 32'h0, "t4.lwMis");
    access(1'b0, 1'b1, 3'd1, 32'h41, 32'hFFFF_FFFF, "t4.shMis");
    access(1'b1, 1'b0, 3'd2, 32'h40, 32'h0, "t4.lw");

    // 5: reset during RESP
    @(negedge clk);
    memRead = 1'b1; memWrite = 1'b0; f3 = 3'd2; addr = 32'h10;
    @(posedge clk);
    @(negedge clk);
    memRead = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5.data", readData, 32'h0);
    check("t5.stall", 32'(stall), 32'h0);
    check("t5.state", 32'(dbgState), 32'h0);
    access(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, "t5.lw");

    // 6: collision acts as a store; aliasing above the RAM size
    access(1'b1, 1'b1, 3'd2, 32'h50, 32'h12345678, "t6.col");
    access(1'b1, 1'b0, 3'd2, 32'h50, 32'h0, "t6.lw");
    check("t6.model", modelLoad(3'd2, 32'h50), 32'h12345678);
    access(1'b0, 1'b1, 3'd2, 32'(MEM_BYTES + 'h50), 32'hCAFE_F00D, "t6.alias");
    access(1'b1, 1'b0, 3'd2, 32'h50, 32'h0, "t6.lwAlias");

    // random mix over the initialised region, with random upper address bits
    for (int n = 0; n < 150; n++) begin
      int op;
      logic [31:0] a;
      op = $urandom_range(0, 9);
      a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255));
      if (op < 4)      access(1'b0, 1'b1, 3'($urandom_range(0, 7)), a, $urandom, "rnd.st");
      else if (op < 9) access(1'b1, 1'b0, 3'($urandom_range(0, 7)), a, $urandom, "rnd.ld");
      else             access(1'b1, 1'b1, 3'($urandom_range(0, 7)), a, $urandom, "rnd.col");
    end

    idleCycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
